cpu_reset_seq: RTL and testbench

Parametrised reset sequencer that produces debounced, stretched, staggered active-low reset outputs for NUM_CH downstream consumers (CPU, peripherals). It sits at the top level of the FPGA design between the board reset button, the CPU PLL lock signal and every block needing a clean power-on/button reset. It adds debounce, PLL-lock gating, hold-time stretching, per-channel release sequencing, cause reporting and an optional watchdog.

---
 rtl/cpu_reset_seq.sv | 173 +++++++++++++++++
 tb/tb_cpu_reset_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cpu_reset_seq.sv
// Reset sequencer: debounced button + PLL-lock gating, hold stretch, staggered
// per-channel active-low release, reset cause reporting. Optional watchdog is
// compiled in with `define CPU_RESET_SEQ_WDT_EN. All outputs registered.
module cpu_reset_seq #(
  parameter int NUM_CH          = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64,
  parameter int STAGGER_CYCLES  = 8,
  parameter int WDT_CYCLES      = 1000000
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              button_reset,
  input  logic              pll_cpu_locked,
  input  logic              wdt_kick,
  output logic [NUM_CH-1:0] resb,
  output logic [1:0]        reset_cause,
  output logic              busy
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int STG_W  = $clog2(STAGGER_CYCLES + 1);
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic btn_m, btn_s, lock_m, lock_s;
  logic btn_db;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [STG_W-1:0]  stg_cnt, stg_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [NUM_CH-1:0] resb_nxt;
  logic [1:0]        cause_nxt, trig_cause;
  logic              trig, wdt_exp;

  // Two-flop synchronisers; button idles released (1), lock idles unlocked (0)
  always_ff @(posedge clk_50) begin
    if (reset) begin
      btn_m  <= 1'b1;
      btn_s  <= 1'b1;
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      btn_m  <= button_reset;
      btn_s  <= btn_m;
      lock_m <= pll_cpu_locked;
      lock_s <= lock_m;
    end
  end

  // Debounce: accept a new button level only after it differs for DEBOUNCE_CYCLES in a row
  always_ff @(posedge clk_50) begin
    if (reset) begin
      btn_db <= 1'b1;
      db_cnt <= '0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      btn_db <= btn_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

`ifdef CPU_RESET_SEQ_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0] wdt_cnt;

  // A kick on the terminal cycle still rescues the system
  assign wdt_exp = (state == ST_RUN) && (wdt_cnt == WDT_W'(WDT_CYCLES - 1)) && !wdt_kick;

  // Watchdog counts only while staying in RUN; saturates at the terminal value
  always_ff @(posedge clk_50) begin
    if (reset) begin
      wdt_cnt <= '0;
    end else if ((state != ST_RUN) || (state_nxt != ST_RUN) || wdt_kick) begin
      wdt_cnt <= '0;
    end else if (wdt_cnt != WDT_W'(WDT_CYCLES - 1)) begin
      wdt_cnt <= wdt_cnt + 1'b1;
    end
  end
`else
  localparam int unused_wdt_cycles = WDT_CYCLES;
  logic unused_wdt_kick;
  assign unused_wdt_kick = wdt_kick;
  assign wdt_exp = 1'b0;
`endif

  // Trigger arbitration: lock loss beats button beats watchdog
  assign trig       = !lock_s || !btn_db || wdt_exp;
  assign trig_cause = !lock_s ? 2'd2 : (!btn_db ? 2'd1 : 2'd3);

  // Next-state and next-output logic; outputs are computed here and registered below
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    stg_nxt   = stg_cnt;
    idx_nxt   = idx;
    resb_nxt  = resb;
    cause_nxt = reset_cause;
    case (state)
      ST_ASSERT: begin
        resb_nxt = '0;
        hold_nxt = '0;
        stg_nxt  = '0;
        idx_nxt  = '0;
        if (lock_s && btn_db) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_nxt = ST_RELEASE;
          hold_nxt  = '0;
          stg_nxt   = '0;
          idx_nxt   = '0;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        stg_nxt = (stg_cnt == STG_W'(STAGGER_CYCLES - 1)) ? '0 : stg_cnt + 1'b1;
        if (stg_cnt == '0) begin
          resb_nxt[idx] = 1'b1;
          if (idx == IDX_W'(NUM_CH - 1)) state_nxt = ST_RUN;
          else                           idx_nxt   = idx + 1'b1;
        end
      end
      default: begin
        resb_nxt = '1;
      end
    endcase
    // Abort from any post-ASSERT state: everything drops together on the next edge
    if (state != ST_ASSERT && trig) begin
      state_nxt = ST_ASSERT;
      resb_nxt  = '0;
      hold_nxt  = '0;
      stg_nxt   = '0;
      idx_nxt   = '0;
      cause_nxt = trig_cause;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state       <= ST_ASSERT;
      hold_cnt    <= '0;
      stg_cnt     <= '0;
      idx         <= '0;
      resb        <= '0;
      reset_cause <= 2'd0;
      busy        <= 1'b1;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_nxt;
      stg_cnt     <= stg_nxt;
      idx         <= idx_nxt;
      resb        <= resb_nxt;
      reset_cause <= cause_nxt;
      busy        <= (state_nxt != ST_RUN);
    end
  end

endmodule

// File: tb/tb_cpu_reset_seq.sv
// Bench for cpu_reset_seq: directed stimulus pushes timed expectations into a
// queue; a negedge monitor pops and compares them against the outputs.
module tb_cpu_reset_seq;

  localparam int NUM_CH = 3;

  logic              clk_50 = 1'b0;
  logic              reset;
  logic              button_reset;
  logic              pll_cpu_locked;
  logic              wdt_kick;
  logic [NUM_CH-1:0] resb;
  logic [1:0]        reset_cause;
  logic              busy;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic auto_kick_en = 1'b1;
  logic man_kick = 1'b0;

  typedef struct {
    int         cyc;
    logic [2:0] resb;
    logic [1:0] cause;
    logic       busy;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  cpu_reset_seq #(
    .NUM_CH(NUM_CH), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8),
    .STAGGER_CYCLES(2), .WDT_CYCLES(10)
  ) dut (
    .clk_50(clk_50), .reset(reset), .button_reset(button_reset),
    .pll_cpu_locked(pll_cpu_locked), .wdt_kick(wdt_kick),
    .resb(resb), .reset_cause(reset_cause), .busy(busy)
  );

  always #5 clk_50 = ~clk_50;

  always @(posedge clk_50) cyc <= cyc + 1;

  // Background kicks keep the optional watchdog quiet outside its own test
  assign wdt_kick = auto_kick_en ? ((cyc % 5) == 0) : man_kick;

  task automatic expect_at(input int off, input logic [2:0] r, input logic [1:0] c,
                           input logic b, input string n);
    exp_t e;
    e.cyc = cyc + off;
    e.resb = r;
    e.cause = c;
    e.busy = b;
    e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk_50);
    #1;
  endtask

  // Monitor: compare every expectation due at this cycle
  always @(negedge clk_50) begin
    while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (e.cyc != cyc || resb !== e.resb || reset_cause !== e.cause || busy !== e.busy) begin
        n_bad++;
        $display("FAIL %s @cyc %0d (due %0d): got resb=%b cause=%0d busy=%b, want resb=%b cause=%0d busy=%b",
                 e.name, cyc, e.cyc, resb, reset_cause, busy, e.resb, e.cause, e.busy);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    button_reset = 1'b1;
    pll_cpu_locked = 1'b1;
    expect_at(3, 3'b000, 2'd0, 1'b1, "in_reset");

    // Power-on: reset released after edge 5, HOLD entered at edge 8
    wait_cycles(5);
    reset = 1'b0;
    expect_at(11, 3'b000, 2'd0, 1'b1, "por_hold");
    expect_at(12, 3'b001, 2'd0, 1'b1, "por_ch0");
    expect_at(14, 3'b011, 2'd0, 1'b1, "por_ch1");
    expect_at(15, 3'b011, 2'd0, 1'b1, "por_ch1_hold");
    expect_at(16, 3'b111, 2'd0, 1'b0, "por_run");
    wait_cycles(20);

    // Bounce: 3 low, 1 high, 3 low never satisfies the 4-cycle debounce
    expect_at(5, 3'b111, 2'd0, 1'b0, "bounce_a");
    expect_at(10, 3'b111, 2'd0, 1'b0, "bounce_b");
    expect_at(15, 3'b111, 2'd0, 1'b0, "bounce_c");
    button_reset = 1'b0; wait_cycles(3);
    button_reset = 1'b1; wait_cycles(1);
    button_reset = 1'b0; wait_cycles(3);
    button_reset = 1'b1; wait_cycles(10);

    // Button press for 20 cycles, then staggered release after debounce
    expect_at(6, 3'b111, 2'd0, 1'b0, "btn_before");
    expect_at(7, 3'b000, 2'd1, 1'b1, "btn_assert");
    expect_at(35, 3'b000, 2'd1, 1'b1, "btn_hold");
    expect_at(36, 3'b001, 2'd1, 1'b1, "btn_ch0");
    expect_at(38, 3'b011, 2'd1, 1'b1, "btn_ch1");
    expect_at(40, 3'b111, 2'd1, 1'b0, "btn_run");
    button_reset = 1'b0; wait_cycles(20);
    button_reset = 1'b1; wait_cycles(22);

    // Simultaneous: lock_s and btn_db both fall on the same edge; lock wins
    expect_at(6, 3'b111, 2'd1, 1'b0, "sim_before");
    expect_at(7, 3'b000, 2'd2, 1'b1, "sim_cause");
    expect_at(30, 3'b111, 2'd2, 1'b0, "sim_rerun");
    button_reset = 1'b0; wait_cycles(4);
    pll_cpu_locked = 1'b0; wait_cycles(6);
    button_reset = 1'b1; pll_cpu_locked = 1'b1; wait_cycles(22);

    // Short button press, then lock loss while resb = 001
    expect_at(7, 3'b000, 2'd1, 1'b1, "btn2_assert");
    expect_at(24, 3'b001, 2'd1, 1'b1, "btn2_ch0");
    expect_at(27, 3'b000, 2'd2, 1'b1, "lock_abort");
    expect_at(40, 3'b000, 2'd2, 1'b1, "lock_wait");
    expect_at(55, 3'b011, 2'd2, 1'b1, "lock_ch1");
    expect_at(56, 3'b111, 2'd2, 1'b0, "lock_run");
    button_reset = 1'b0; wait_cycles(8);
    button_reset = 1'b1; wait_cycles(16);
    pll_cpu_locked = 1'b0; wait_cycles(16);
    pll_cpu_locked = 1'b1; wait_cycles(16);

    // Watchdog: four kicks 9 cycles apart, then silence
    auto_kick_en = 1'b0;
    expect_at(37, 3'b111, 2'd2, 1'b0, "wdt_kicked");
`ifdef CPU_RESET_SEQ_WDT_EN
    expect_at(38, 3'b000, 2'd3, 1'b1, "wdt_expire");
`else
    expect_at(38, 3'b111, 2'd2, 1'b0, "wdt_absent");
`endif
    for (int k = 0; k < 4; k++) begin
      man_kick = 1'b1; wait_cycles(1);
      man_kick = 1'b0; wait_cycles(8);
    end
    wait_cycles(4);

    // Synchronous reset mid-flight restores reset values on the next edge
    auto_kick_en = 1'b1;
    expect_at(1, 3'b000, 2'd0, 1'b1, "mid_reset");
    reset = 1'b1; wait_cycles(2);
    reset = 1'b0; wait_cycles(3);

    if (exp_q.size() != 0) begin
      $display("FAIL unchecked: %0d expectations never reached, want 0", exp_q.size());
      n_bad += exp_q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
